// File: rtl/sum_feeder.sv
// sum_feeder: streams a software-loaded operand list into the summing accumulator,
// then checks the accumulator's returned sum against a locally computed expectation.
module sum_feeder #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         clear_list,
    input  logic                         start,
    input  logic                         done,
    input  logic [WIDTH-1:0]             sum,
    output logic                         go_l,
    output logic [WIDTH-1:0]             inA,
    output logic [WIDTH-1:0]             exp_sum,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         wr_rej,
    output logic                         match,
    output logic                         mismatch,
    output logic                         timeout
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_STREAM,
        S_TERM,
        S_WAIT_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_list [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_k;
    logic [TW-1:0]    r_wait;
    logic [WIDTH-1:0] r_exp_sum;
    logic             r_wr_rej;
    logic             r_match;
    logic             r_mismatch;
    logic             r_timeout;

    logic             w_idle;
    logic             w_wr_ok;
    logic             w_start_ok;
    logic             w_last_k;
    logic             w_wait_last;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    // A zero operand would terminate the accumulator early, so it is never stored.
    assign w_idle      = (r_state == S_IDLE);
    assign w_wr_ok     = wr_en && w_idle && (wr_data != '0) && (r_count != DEPTH_C) && !clear_list;
    assign w_start_ok  = w_idle && start && (r_count != '0);
    assign w_last_k    = ((r_k + CW'(1)) == r_count);
    assign w_wait_last = (r_wait == WAIT_LAST);
    assign w_wr_idx    = r_count[AW-1:0];
    assign w_rd_idx    = r_k[AW-1:0];

    // NOTE: every output and next-state gets a default first, so no path infers a latch.
    always_comb begin
        w_next = r_state;
        go_l   = 1'b1;
        inA    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next = S_GO;
            end
            S_GO: begin
                go_l   = 1'b0;
                w_next = S_STREAM;
            end
            S_STREAM: begin
                inA = r_list[w_rd_idx];
                if (w_last_k) w_next = S_TERM;
            end
            S_TERM: begin
                w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done || w_wait_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= only, so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_k        <= '0;
            r_wait     <= '0;
            r_exp_sum  <= '0;
            r_wr_rej   <= 1'b0;
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_wr_rej <= wr_en && !w_wr_ok;

            // An accepted start takes priority over a same-cycle clear.
            if (w_wr_ok) begin
                r_count <= r_count + CW'(1);
            end else if (clear_list && w_idle && !w_start_ok) begin
                r_count <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_match    <= 1'b0;
                        r_mismatch <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_exp_sum  <= '0;
                    end
                end
                S_GO: r_k <= '0;
                S_STREAM: begin
                    r_exp_sum <= r_exp_sum + r_list[w_rd_idx];
                    r_k       <= r_k + CW'(1);
                end
                S_TERM: r_wait <= '0;
                S_WAIT_DONE: begin
                    if (done) begin
                        r_match    <= (sum == r_exp_sum);
                        r_mismatch <= (sum != r_exp_sum);
                    end else if (w_wait_last) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the list storage is not reset; count alone defines which entries are valid.
    always_ff @(posedge clock) begin
        if (w_wr_ok) r_list[w_wr_idx] <= wr_data;
    end

    assign busy     = !w_idle;
    assign count    = r_count;
    assign exp_sum  = r_exp_sum;
    assign wr_rej   = r_wr_rej;
    assign match    = r_match;
    assign mismatch = r_mismatch;
    assign timeout  = r_timeout;
endmodule

// File: tb/tb_sum_feeder.sv
// tb_sum_feeder: scenario tasks plus randomized runs, checked against a queue-based
// model of the operand list and its modulo-2^WIDTH sum.
module tb_sum_feeder;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             clear_list;
    logic             start;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             go_l;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] exp_sum;
    logic [CW-1:0]    count;
    logic             busy;
    logic             wr_rej;
    logic             match;
    logic             mismatch;
    logic             timeout;

    int checks   = 0;
    int failures = 0;
    int model[$];

    sum_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .clear_list(clear_list), .start(start), .done(done), .sum(sum),
        .go_l(go_l), .inA(inA), .exp_sum(exp_sum), .count(count), .busy(busy),
        .wr_rej(wr_rej), .match(match), .mismatch(mismatch), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int model_sum();
        int s = 0;
        foreach (model[i]) s += model[i];
        return s % (1 << WIDTH);
    endfunction

    task automatic check_idle_reset_values(input string name);
        checks++; if (go_l !== 1'b1) begin failures++; $display("FAIL %s go_l got=%0b exp=1", name, go_l); end
        checks++; if (inA !== '0) begin failures++; $display("FAIL %s inA got=%0d exp=0", name, inA); end
        checks++; if (exp_sum !== '0) begin failures++; $display("FAIL %s exp_sum got=%0d exp=0", name, exp_sum); end
        checks++; if (count !== '0) begin failures++; $display("FAIL %s count got=%0d exp=0", name, count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy got=%0b exp=0", name, busy); end
        checks++; if (wr_rej !== 1'b0) begin failures++; $display("FAIL %s wr_rej got=%0b exp=0", name, wr_rej); end
        checks++; if ({match, mismatch, timeout} !== 3'b000) begin
            failures++; $display("FAIL %s flags got=%03b exp=000", name, {match, mismatch, timeout});
        end
    endtask

    task automatic write_entry(input string name, input int val);
        bit acc;
        acc     = (val != 0) && (model.size() < DEPTH);
        wr_en   = 1'b1;
        wr_data = WIDTH'(val);
        tick();
        wr_en   = 1'b0;
        if (acc) model.push_back(val);
        checks++; if (wr_rej !== !acc) begin failures++; $display("FAIL %s wr_rej got=%0b exp=%0b val=%0d", name, wr_rej, !acc, val); end
        checks++; if (count !== CW'(model.size())) begin failures++; $display("FAIL %s count got=%0d exp=%0d", name, count, model.size()); end
    endtask

    task automatic clear_all(input string name);
        clear_list = 1'b1;
        tick();
        clear_list = 1'b0;
        model.delete();
        checks++; if (count !== '0) begin failures++; $display("FAIL %s clear count got=%0d exp=0", name, count); end
    endtask

    // done_at: WAIT_DONE cycle in which done is driven (-1 = never); ret_sum -1 returns the correct sum.
    task automatic run_list(input string name, input int done_at, input int ret_sum,
                            input bit pokes, input bit done_in_stream);
        int es;
        int rs;
        bit got;
        logic [2:0] exp_flags;
        es  = model_sum();
        rs  = (ret_sum < 0) ? es : ret_sum;
        got = 1'b0;
        start = 1'b1;
        tick();
        start = pokes;
        checks++; if (go_l !== 1'b0) begin failures++; $display("FAIL %s GO go_l got=%0b exp=0", name, go_l); end
        checks++; if (inA !== '0) begin failures++; $display("FAIL %s GO inA got=%0d exp=0", name, inA); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s GO busy got=%0b exp=1", name, busy); end
        checks++; if ({match, mismatch, timeout} !== 3'b000) begin
            failures++; $display("FAIL %s GO flags got=%03b exp=000", name, {match, mismatch, timeout});
        end
        checks++; if (exp_sum !== '0) begin failures++; $display("FAIL %s GO exp_sum got=%0d exp=0", name, exp_sum); end
        if (pokes) begin
            wr_en   = 1'b1;
            wr_data = 8'd7;
        end
        for (int i = 0; i < model.size(); i++) begin
            if (done_in_stream) begin
                done = 1'b1;
                sum  = WIDTH'(es);
            end
            tick();
            if (pokes) begin
                checks++; if (wr_rej !== (i == 0)) begin failures++; $display("FAIL %s busy wr_rej got=%0b exp=%0b", name, wr_rej, (i == 0)); end
                wr_en      = 1'b0;
                start      = 1'b0;
                clear_list = (i == 0);
            end
            checks++; if (go_l !== 1'b1) begin failures++; $display("FAIL %s STREAM go_l got=%0b exp=1", name, go_l); end
            checks++; if (inA !== WIDTH'(model[i])) begin failures++; $display("FAIL %s STREAM inA[%0d] got=%0d exp=%0d", name, i, inA, model[i]); end
        end
        done       = 1'b0;
        clear_list = 1'b0;
        wr_en      = 1'b0;
        start      = 1'b0;
        tick();
        checks++; if (inA !== '0) begin failures++; $display("FAIL %s TERM inA got=%0d exp=0", name, inA); end
        checks++; if (go_l !== 1'b1) begin failures++; $display("FAIL %s TERM go_l got=%0b exp=1", name, go_l); end
        checks++; if (exp_sum !== WIDTH'(es)) begin failures++; $display("FAIL %s TERM exp_sum got=%0d exp=%0d", name, exp_sum, es); end
        for (int w = 0; w < TIMEOUT && !got; w++) begin
            tick();
            checks++; if (busy !== 1'b1 || inA !== '0) begin
                failures++; $display("FAIL %s WAIT%0d busy/inA got=%0b/%0d exp=1/0", name, w, busy, inA);
            end
            if (w == done_at) begin
                done = 1'b1;
                sum  = WIDTH'(rs);
                tick();
                done = 1'b0;
                got  = 1'b1;
            end
        end
        if (!got) tick();
        exp_flags = !got ? 3'b001 : ((rs == es) ? 3'b100 : 3'b010);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s end busy got=%0b exp=0", name, busy); end
        checks++; if ({match, mismatch, timeout} !== exp_flags) begin
            failures++; $display("FAIL %s end flags got=%03b exp=%03b", name, {match, mismatch, timeout}, exp_flags);
        end
        checks++; if (exp_sum !== WIDTH'(es)) begin failures++; $display("FAIL %s end exp_sum got=%0d exp=%0d", name, exp_sum, es); end
        checks++; if (count !== CW'(model.size())) begin failures++; $display("FAIL %s end count got=%0d exp=%0d", name, count, model.size()); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model.delete();
        check_idle_reset_values("reset");
    endtask

    task automatic test_basic_match();
        for (int i = 0; i < 3; i++) write_entry("basic_wr", 4);
        run_list("basic", 2, 12, 1'b0, 1'b0);
    endtask

    task automatic test_mismatch();
        clear_all("mismatch");
        for (int i = 0; i < 3; i++) write_entry("mismatch_wr", 3);
        run_list("mismatch", 1, 8, 1'b0, 1'b0);
        run_list("mismatch_rerun", 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        clear_all("wrap");
        write_entry("wrap_wr", 200);
        write_entry("wrap_wr", 100);
        run_list("wrap", 3, 44, 1'b0, 1'b0);
    endtask

    task automatic test_list_limits();
        clear_all("limits");
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b0 || go_l !== 1'b1) begin failures++; $display("FAIL empty_start busy/go_l got=%0b/%0b exp=0/1", busy, go_l); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_start later busy got=%0b exp=0", busy); end
        checks++; if (match !== 1'b1) begin failures++; $display("FAIL empty_start sticky match got=%0b exp=1", match); end
        for (int i = 0; i < DEPTH + 1; i++) write_entry("fill", $urandom_range(1, 255));
        tick();
        checks++; if (wr_rej !== 1'b0) begin failures++; $display("FAIL wr_rej_pulse got=%0b exp=0", wr_rej); end
        clear_all("limits2");
        write_entry("zero_pre", 9);
        write_entry("zero_wr", 0);
        wr_en      = 1'b1;
        wr_data    = 8'd6;
        clear_list = 1'b1;
        tick();
        wr_en      = 1'b0;
        clear_list = 1'b0;
        model.delete();
        checks++; if (wr_rej !== 1'b1 || count !== '0) begin failures++; $display("FAIL wr_with_clear wr_rej/count got=%0b/%0d exp=1/0", wr_rej, count); end
    endtask

    task automatic test_timeout();
        clear_all("timeout");
        write_entry("timeout_wr", 5);
        run_list("timeout", -1, -1, 1'b0, 1'b0);
        run_list("done_last_cycle", TIMEOUT - 1, -1, 1'b0, 1'b0);
        run_list("timeout_again", -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        clear_all("midrst");
        write_entry("midrst_wr", 10);
        write_entry("midrst_wr", 20);
        write_entry("midrst_wr", 30);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++; if (inA !== 8'd20) begin failures++; $display("FAIL midrst k1 inA got=%0d exp=20", inA); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model.delete();
        check_idle_reset_values("midrst");
    endtask

    task automatic test_back_to_back();
        clear_all("b2b");
        write_entry("b2b_wr", 17);
        write_entry("b2b_wr", 250);
        write_entry("b2b_wr", 1);
        run_list("busy_pokes", 4, -1, 1'b1, 1'b1);
        run_list("b2b_second", 0, 99, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int n;
            int r;
            int done_at;
            int ret;
            bit pokes;
            clear_all("rand");
            n = $urandom_range(1, DEPTH);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 5) == 0) write_entry("rand_zero", 0);
                write_entry("rand_wr", $urandom_range(1, 255));
            end
            r       = $urandom_range(0, 19);
            done_at = (r >= TIMEOUT) ? -1 : r;
            ret     = $urandom_range(0, 1) ? -1 : int'($urandom_range(0, 255));
            pokes   = (n >= 2) && ($urandom_range(0, 1) == 1);
            run_list("rand_run", done_at, ret, pokes, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_data    = '0;
        clear_list = 1'b0;
        start      = 1'b0;
        done       = 1'b0;
        sum        = '0;
        test_reset();
        test_basic_match();
        test_mismatch();
        test_wrap();
        test_list_limits();
        test_timeout();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
